// File: rtl/game_pkg.sv
// Shared types and constants for the Mental Math game stages.
package game_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GEN      = 3'd1,
        WAIT_ANS = 3'd2,
        CHECK    = 3'd3,
        FEEDBACK = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Feedback taps b7, b5, b4, b3 of the 8-bit Fibonacci LFSR
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam int OP_W    = 4;
    localparam int ANS_W   = 5;
    localparam int SCORE_W = 4;
endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, shift-left, advances only when step is high.
module lfsr8
    import game_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [7:0] state
);
    always_ff @(posedge clk) begin
        if (!rst)
            state <= SEED;
        else if (step)
            state <= {state[6:0], ^(state & LFSR_TAPS)};
    end
endmodule

// File: rtl/game_round_controller.sv
// Mental Math round sequencer: operand generation, answer timing, scoring.
module game_round_controller
    import game_pkg::*;
#(
    parameter int         CLK_PER_TICK = 50000000,
    parameter int         ROUND_TICKS  = 10,
    parameter int         NUM_ROUNDS   = 8,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               logged_in,
    input  logic               submit,
    input  logic [ANS_W-1:0]   answer,
    output logic [OP_W-1:0]    operand_a,
    output logic [OP_W-1:0]    operand_b,
    output logic [3:0]         round_num,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         time_left,
    output logic               correct,
    output logic               wrong,
    output logic               game_over
);
    localparam int            TW        = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_TICK - 1);
    localparam logic [3:0]    LAST_RND  = 4'(NUM_ROUNDS - 1);

    state_t           state, next_state;
    logic [TW-1:0]    tick_cnt;
    logic [ANS_W-1:0] ans_q;
    logic [7:0]       lfsr;
    logic             lfsr_step;
    logic             tick_wrap;
    logic [ANS_W-1:0] sum;

    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign sum       = {1'b0, operand_a} + {1'b0, operand_b};

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .state (lfsr)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state != IDLE && !logged_in)
            next_state = IDLE;
        else begin
            case (state)
                IDLE:     if (logged_in) next_state = GEN;
                GEN:      next_state = WAIT_ANS;
                // submit takes priority over a timeout on the same edge
                WAIT_ANS: if (submit) next_state = CHECK;
                          else if (tick_wrap && time_left == 4'd1) next_state = FEEDBACK;
                CHECK:    next_state = FEEDBACK;
                FEEDBACK: if (tick_wrap) next_state = (round_num == LAST_RND) ? DONE : GEN;
                DONE:     next_state = DONE;
                default:  next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        game_over = (state == DONE);
        lfsr_step = (state == GEN);
    end

    always_ff @(posedge clk) begin
        if (!rst || state == IDLE || !logged_in) begin
            operand_a <= '0;
            operand_b <= '0;
            round_num <= '0;
            score     <= '0;
            time_left <= '0;
            correct   <= 1'b0;
            wrong     <= 1'b0;
            tick_cnt  <= '0;
            ans_q     <= '0;
        end else begin
            case (state)
                GEN: begin
                    operand_a <= lfsr[7:4];
                    operand_b <= lfsr[3:0];
                    time_left <= 4'(ROUND_TICKS);
                    tick_cnt  <= '0;
                end
                WAIT_ANS: begin
                    tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
                    if (tick_wrap) time_left <= time_left - 4'd1;
                    if (submit)
                        ans_q <= answer;
                    else if (tick_wrap && time_left == 4'd1)
                        wrong <= 1'b1;
                end
                CHECK: begin
                    if (ans_q == sum) begin
                        correct <= 1'b1;
                        score   <= score + 4'd1;
                    end else
                        wrong <= 1'b1;
                    tick_cnt <= '0;
                end
                FEEDBACK: begin
                    if (tick_wrap) begin
                        tick_cnt <= '0;
                        correct  <= 1'b0;
                        wrong    <= 1'b0;
                        if (round_num != LAST_RND) round_num <= round_num + 4'd1;
                    end else
                        tick_cnt <= tick_cnt + TW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench: scoreboard for feedback/game_over events plus inline state checks.
module tb_game_round_controller;
    logic       clk = 1'b0;
    logic       rst, logged_in, submit;
    logic [4:0] answer;
    logic [3:0] operand_a, operand_b, round_num, score, time_left;
    logic       correct, wrong, game_over;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       c;
        logic       w;
        logic       g;
        logic [3:0] s;
        logic [3:0] r;
    } ev_t;
    ev_t exp_q[$];

    game_round_controller #(
        .CLK_PER_TICK(4), .ROUND_TICKS(3), .NUM_ROUNDS(2), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .logged_in(logged_in), .submit(submit), .answer(answer),
        .operand_a(operand_a), .operand_b(operand_b), .round_num(round_num), .score(score),
        .time_left(time_left), .correct(correct), .wrong(wrong), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Monitor: pops one expectation on each rising correct/wrong/game_over
    logic pc = 1'b0, pw = 1'b0, pg = 1'b0;
    always @(negedge clk) begin
        ev_t e, a;
        if ((correct && !pc) || (wrong && !pw) || (game_over && !pg)) begin
            a = '{c: correct, w: wrong, g: game_over, s: score, r: round_num};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL event_unexpected got=%h", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL event got c=%b w=%b g=%b s=%0d r=%0d want c=%b w=%b g=%b s=%0d r=%0d",
                             a.c, a.w, a.g, a.s, a.r, e.c, e.w, e.g, e.s, e.r);
                end
            end
        end
        pc <= correct;
        pw <= wrong;
        pg <= game_over;
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({operand_a, operand_b, round_num, score, time_left, correct, wrong, game_over});
    endfunction

    task automatic push(input logic c, input logic w, input logic g, input logic [3:0] s, input logic [3:0] r);
        exp_q.push_back('{c: c, w: w, g: g, s: s, r: r});
    endtask

    // Counts cycles the feedback flag stays high (bounded)
    task automatic fb_width(input string name);
        int n = 0;
        while ((correct || wrong) && n < 20) begin
            n++;
            cyc();
        end
        chk(name, 32'(n), 32'd4);
    endtask

    task automatic pulse(input logic [4:0] v);
        answer = v;
        submit = 1'b1;
        cyc();
        submit = 1'b0;
    endtask

    task automatic start_round(input string name, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] r, input logic [3:0] s);
        chk({name, "_a"}, 32'(operand_a), 32'(a));
        chk({name, "_b"}, 32'(operand_b), 32'(b));
        chk({name, "_round"}, 32'(round_num), 32'(r));
        chk({name, "_score"}, 32'(score), 32'(s));
        chk({name, "_tl"}, 32'(time_left), 32'd3);
    endtask

    initial begin
        rst = 1'b0; logged_in = 1'b0; submit = 1'b0; answer = '0;
        cyc(3);
        chk("reset_outs", outs(), 32'd0);
        rst = 1'b1;
        cyc();
        chk("idle_outs", outs(), 32'd0);

        // Game 1 round 0: A+5=15, correct
        logged_in = 1'b1;
        cyc(2);
        start_round("g1r0", 4'hA, 4'h5, 4'd0, 4'd0);
        push(1, 0, 0, 4'd1, 4'd0);
        pulse(5'd15);
        cyc();
        chk("g1r0_correct", 32'(correct), 32'd1);
        fb_width("g1r0_fb_width");
        cyc();
        start_round("g1r1", 4'h4, 4'hA, 4'd1, 4'd1);

        // Round 1: 4+A=14, answer 13 wrong, then DONE
        push(0, 1, 0, 4'd1, 4'd1);
        push(0, 0, 1, 4'd1, 4'd1);
        pulse(5'd13);
        cyc();
        chk("g1r1_wrong", 32'(wrong), 32'd1);
        fb_width("g1r1_fb_width");
        chk("g1_over", 32'(game_over), 32'd1);
        chk("g1_round", 32'(round_num), 32'd1);
        pulse(5'd14);
        pulse(5'd14);
        chk("done_submit_ignored", 32'(score), 32'd1);
        logged_in = 1'b0;
        cyc();
        chk("logout_outs", outs(), 32'd0);

        // Game 2 round 0: timeout (lfsr 95)
        logged_in = 1'b1;
        cyc(2);
        start_round("g2r0", 4'h9, 4'h5, 4'd0, 4'd0);
        push(0, 1, 0, 4'd0, 4'd0);
        cyc(3);
        chk("tl_e3", 32'(time_left), 32'd3);
        cyc();
        chk("tl_e4", 32'(time_left), 32'd2);
        cyc(4);
        chk("tl_e8", 32'(time_left), 32'd1);
        cyc(3);
        chk("tl_e11_wrong", 32'({time_left, wrong}), 32'({4'd1, 1'b0}));
        cyc();
        chk("tl_e12_timeout", 32'({time_left, wrong, score}), 32'({4'd0, 1'b1, 4'd0}));
        fb_width("g2r0_fb_width");
        cyc();
        start_round("g2r1", 4'h2, 4'hA, 4'd1, 4'd0);

        // Round 1: submit on the final wrap edge, correct wins
        cyc(11);
        push(1, 0, 0, 4'd1, 4'd1);
        push(0, 0, 1, 4'd1, 4'd1);
        pulse(5'd12);
        cyc();
        chk("g2r1_correct", 32'({correct, wrong, score}), 32'({1'b1, 1'b0, 4'd1}));
        fb_width("g2r1_fb_width");
        chk("g2_over", 32'(game_over), 32'd1);
        logged_in = 1'b0;
        cyc();

        // Game 3: abort mid-WAIT_ANS (lfsr 54), restart uses A9
        logged_in = 1'b1;
        cyc(2);
        chk("g3_ops", 32'({operand_a, operand_b}), 32'h54);
        cyc(2);
        logged_in = 1'b0;
        cyc();
        chk("abort_outs", outs(), 32'd0);
        logged_in = 1'b1;
        cyc(2);
        start_round("g4r0", 4'hA, 4'h9, 4'd0, 4'd0);

        // Reset during FEEDBACK restores the seed
        push(1, 0, 0, 4'd1, 4'd0);
        pulse(5'd19);
        cyc(2);
        rst = 1'b0;
        cyc();
        chk("rst_fb_outs", outs(), 32'd0);
        rst = 1'b1;
        cyc(2);
        start_round("post_rst", 4'hA, 4'h5, 4'd0, 4'd0);

        cyc(2);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
